// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared CP0 definitions: register numbers, Cause.IP bit positions, exception
// codes, the packed interrupt-source vector and a register-decode helper.
// The interrupt front end uses this package now; the CP0 exception unit will
// move onto the same definitions so both decode the MTC0 bus identically.
// -----------------------------------------------------------------------------
package cp0_pkg;

    // CP0 register numbers (all at select 0)
    localparam logic [4:0] BADINSTR = 5'd8;
    localparam logic [4:0] COUNT    = 5'd9;
    localparam logic [4:0] COMPARE  = 5'd11;
    localparam logic [4:0] STATUS   = 5'd12;
    localparam logic [4:0] CAUSE    = 5'd13;
    localparam logic [4:0] EPC      = 5'd14;
    localparam logic [4:0] IRQ_PEND = 5'd22;

    // Bit positions inside the 8-bit interrupt source / Cause.IP field
    localparam int IP_TIMER  = 7;
    localparam int IP_EXT_LO = 2;
    localparam int IP_SW_LO  = 0;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_IBE  = 5'd6;
    localparam logic [4:0] EXC_DBE  = 5'd7;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    // Layout matches Cause[15:8]: {IP7 timer, IP6..IP2 external, IP1..IP0 sw}
    typedef struct packed {
        logic       timer;
        logic [4:0] ext;
        logic [1:0] sw;
    } ip_vec_t;

    // True when the regnum/sel bus addresses register 'target' at select 0
    function automatic logic reg_is(input logic [4:0] rn,
                                    input logic [2:0] sl,
                                    input logic [4:0] target);
        return (rn == target) && (sl == 3'd0);
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// One external interrupt line: two-flop synchroniser, plus (edge mode only) a
// history flop and a sticky pending flop that latches rising edges.
//
// Ports
//   clock  in   core clock
//   reset  in   asynchronous, active-high
//   irq    in   asynchronous interrupt line
//   clear  in   write-1-to-clear strobe for the pending flop (edge mode)
//   src    out  value presented to the interrupt vector (level: s2, edge: pend)
//   pend   out  latched edge pending bit (always 0 in level mode)
// -----------------------------------------------------------------------------
module irq_sync_edge #(
    parameter bit EDGE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic irq,
    input  logic clear,
    output logic src,
    output logic pend
);

    logic s1;
    logic s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= irq;
            s2 <= s1;
        end
    end

    if (EDGE) begin : g_edge
        logic s3;
        logic pend_q;

        // A new edge beats a simultaneous clear so no edge is ever dropped.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                s3     <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                s3 <= s2;
                if (s2 && !s3) begin
                    pend_q <= 1'b1;
                end else if (clear) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign src  = pend_q;
        assign pend = pend_q;
    end else begin : g_level
        // Level lines have no pending state; the clear strobe is irrelevant.
        logic unused_clear;
        assign unused_clear = clear;
        assign src  = s2;
        assign pend = 1'b0;
    end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_irq_ctrl
// Interrupt-source front end for the CP0 exception unit. Owns the Count /
// Compare timer, the two software interrupt bits and the synchronised external
// interrupt lines, and produces the 8-bit vector CP0 merges into Cause[15:8].
//
// Ports
//   clock             in   core clock
//   reset             in   asynchronous, active-high
//   wr_data[63:0]     in   MTC0 write data (bits [31:0] used)
//   regnum[4:0]       in   CP0 register number
//   sel[2:0]          in   CP0 select
//   MTC0              in   write strobe
//   ext_irq[4:0]      in   asynchronous external interrupt lines
//   rd_data[63:0]     out  combinational read data, zero when rd_hit=0
//   rd_hit            out  regnum/sel addresses Count, Compare or IRQ_PEND
//   interrupt_source  out  {timer, ext[4:0], sw[1:0]}, all from flops
// -----------------------------------------------------------------------------
module cp0_irq_ctrl
    import cp0_pkg::*;
#(
    parameter int          COUNT_DIV     = 2,
    parameter logic [4:0]  EXT_EDGE      = 5'b00000,
    parameter logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] wr_data,
    input  logic [4:0]  regnum,
    input  logic [2:0]  sel,
    input  logic        MTC0,
    input  logic [4:0]  ext_irq,
    output logic [63:0] rd_data,
    output logic        rd_hit,
    output logic [7:0]  interrupt_source
);

    localparam int             PW         = $clog2(COUNT_DIV) + 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(COUNT_DIV - 1);

    logic          wr_count;
    logic          wr_compare;
    logic          wr_cause;
    logic          wr_pend;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_nxt;
    logic [31:0]   count_q;
    logic [31:0]   count_nxt;
    logic          count_upd;
    logic [31:0]   compare_q;
    logic          match_set;
    logic          timer_pend_q;
    logic [1:0]    sw_q;

    logic [4:0]    pend_clr;
    logic [4:0]    ext_src;
    logic [4:0]    ext_pend;
    ip_vec_t       ip;

    logic          unused_wr_hi;
    assign unused_wr_hi = ^wr_data[63:32];

    assign wr_count   = MTC0 && reg_is(regnum, sel, COUNT);
    assign wr_compare = MTC0 && reg_is(regnum, sel, COMPARE);
    assign wr_cause   = MTC0 && reg_is(regnum, sel, CAUSE);
    assign wr_pend    = MTC0 && reg_is(regnum, sel, IRQ_PEND);

    // Count either loads from MTC0 (restarting the prescaler) or steps on
    // prescaler wrap; count_upd marks the edges where Count takes a new value.
    always_comb begin
        presc_nxt = presc_q + 1'b1;
        count_nxt = count_q;
        count_upd = 1'b0;
        if (wr_count) begin
            presc_nxt = '0;
            count_nxt = wr_data[31:0];
            count_upd = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
            presc_nxt = '0;
            count_nxt = count_q + 32'd1;
            count_upd = 1'b1;
        end
    end

    // Only a change of Count can match, so rewriting Compare to the current
    // Count value does not fire until Count arrives there again.
    assign match_set = count_upd && (count_nxt == compare_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            count_q      <= '0;
            compare_q    <= COMPARE_RESET;
            timer_pend_q <= 1'b0;
            sw_q         <= 2'b00;
        end else begin
            presc_q <= presc_nxt;
            count_q <= count_nxt;
            if (wr_compare) begin
                compare_q <= wr_data[31:0];
            end
            // Compare write acknowledges the timer even against a fresh match.
            if (wr_compare) begin
                timer_pend_q <= 1'b0;
            end else if (match_set) begin
                timer_pend_q <= 1'b1;
            end
            if (wr_cause) begin
                sw_q <= wr_data[9:8];
            end
        end
    end

    assign pend_clr = {5{wr_pend}} & wr_data[4:0];

    for (genvar i = 0; i < 5; i++) begin : g_ext
        irq_sync_edge #(
            .EDGE (EXT_EDGE[i])
        ) u_sync (
            .clock (clock),
            .reset (reset),
            .irq   (ext_irq[i]),
            .clear (pend_clr[i]),
            .src   (ext_src[i]),
            .pend  (ext_pend[i])
        );
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        if (reg_is(regnum, sel, COUNT)) begin
            rd_hit  = 1'b1;
            rd_data = {32'b0, count_q};
        end else if (reg_is(regnum, sel, COMPARE)) begin
            rd_hit  = 1'b1;
            rd_data = {32'b0, compare_q};
        end else if (reg_is(regnum, sel, IRQ_PEND)) begin
            rd_hit  = 1'b1;
            rd_data = {59'b0, ext_pend};
        end
    end

    assign ip.timer         = timer_pend_q;
    assign ip.ext           = ext_src;
    assign ip.sw            = sw_q;
    assign interrupt_source = ip;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_irq_ctrl
// Self-checking bench for cp0_irq_ctrl (COUNT_DIV=2, ext line 0 edge mode,
// the rest level). Each scenario queues its expected values while driving
// stimulus, records what the DUT shows at the sample points, and compares the
// two in order at the end of the scenario.
// -----------------------------------------------------------------------------
module tb_cp0_irq_ctrl;
    import cp0_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] wr_data;
    logic [4:0]  regnum;
    logic [2:0]  sel;
    logic        MTC0;
    logic [4:0]  ext_irq;
    logic [63:0] rd_data;
    logic        rd_hit;
    logic [7:0]  interrupt_source;

    typedef struct {
        string       name;
        logic [63:0] val;
    } sb_t;

    sb_t         sb_q[$];
    logic [63:0] obs_q[$];
    int          checks = 0;
    int          errors = 0;

    cp0_irq_ctrl #(
        .COUNT_DIV     (2),
        .EXT_EDGE      (5'b00001),
        .COMPARE_RESET (32'hFFFF_FFFF)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .wr_data          (wr_data),
        .regnum           (regnum),
        .sel              (sel),
        .MTC0             (MTC0),
        .ext_irq          (ext_irq),
        .rd_data          (rd_data),
        .rd_hit           (rd_hit),
        .interrupt_source (interrupt_source)
    );

    always #10 clock = ~clock;

    task automatic expect_val(input string n, input logic [63:0] v);
        sb_t e;
        e.name = n;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [63:0] v);
        obs_q.push_back(v);
    endtask

    task automatic rd(input logic [4:0] r, input logic [2:0] s,
                      output logic [63:0] v, output logic h);
        regnum = r;
        sel    = s;
        #1;
        v = rd_data;
        h = rd_hit;
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [63:0] d);
        @(negedge clock);
        regnum  = r;
        sel     = s;
        wr_data = d;
        MTC0    = 1'b1;
        @(posedge clock);
        #1;
        MTC0    = 1'b0;
        wr_data = '0;
    endtask

    task automatic test_reset;
        logic [63:0] v;
        logic        h;
        reset   = 1'b1;
        MTC0    = 1'b0;
        wr_data = '0;
        regnum  = '0;
        sel     = '0;
        ext_irq = '0;
        repeat (2) @(posedge clock);
        #1;
        expect_val("rst_irq_src", 64'h0);
        observe(64'(interrupt_source));
        expect_val("rst_count", 64'h0);
        rd(COUNT, 3'd0, v, h);
        observe(v);
        @(negedge clock);
        reset = 1'b0;
        expect_val("count_after_10", 64'd5);
        expect_val("count_hit", 64'd1);
        expect_val("compare_rst", 64'hFFFF_FFFF);
        expect_val("idle_irq_src", 64'h0);
        expect_val("cause_no_hit", 64'h0);
        expect_val("cause_rd_zero", 64'h0);
        expect_val("pend_hit", 64'd1);
        repeat (10) @(posedge clock);
        #1;
        rd(COUNT, 3'd0, v, h);
        observe(v);
        observe({63'b0, h});
        rd(COMPARE, 3'd0, v, h);
        observe(v);
        observe(64'(interrupt_source));
        rd(CAUSE, 3'd0, v, h);
        observe({63'b0, h});
        observe(v);
        rd(IRQ_PEND, 3'd0, v, h);
        observe({63'b0, h});
        // Write to Count's regnum with sel=1 is not ours: Count untouched.
        expect_val("bad_sel_no_hit", 64'h0);
        expect_val("bad_sel_count", 64'd5);
        mtc0(COUNT, 3'd1, 64'h1234);
        rd(COUNT, 3'd1, v, h);
        observe({63'b0, h});
        rd(COUNT, 3'd0, v, h);
        observe(v);
        while (sb_q.size() != 0) begin
            sb_t e;
            logic [63:0] got;
            e = sb_q.pop_front();
            if (obs_q.size() != 0) got = obs_q.pop_front();
            else got = 'x;
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_timer_match;
        logic [63:0] v;
        logic        h;
        mtc0(COUNT, 3'd0, 64'h10);
        mtc0(COMPARE, 3'd0, 64'h14);
        expect_val("tm_before_match", 64'h0);
        expect_val("tm_at_match", 64'h1);
        expect_val("tm_count_at_match", 64'h14);
        expect_val("tm_sticky", 64'h80);
        expect_val("tm_cleared", 64'h0);
        repeat (6) @(posedge clock);
        #1;
        observe(64'(interrupt_source[IP_TIMER]));
        @(posedge clock);
        #1;
        observe(64'(interrupt_source[IP_TIMER]));
        rd(COUNT, 3'd0, v, h);
        observe(v);
        repeat (4) @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        mtc0(COMPARE, 3'd0, 64'h40);
        observe(64'(interrupt_source));
        while (sb_q.size() != 0) begin
            sb_t e;
            logic [63:0] got;
            e = sb_q.pop_front();
            if (obs_q.size() != 0) got = obs_q.pop_front();
            else got = 'x;
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_compare_coincide;
        logic [63:0] v;
        logic        h;
        mtc0(COUNT, 3'd0, 64'h10);
        mtc0(COMPARE, 3'd0, 64'h14);
        expect_val("cc_pend_after_clash", 64'h0);
        expect_val("cc_count_at_clash", 64'h14);
        expect_val("cc_count_next", 64'h15);
        expect_val("cc_pend_later", 64'h0);
        repeat (6) @(posedge clock);
        // Rewrite Compare on the very edge Count reaches 0x14.
        mtc0(COMPARE, 3'd0, 64'h14);
        observe(64'(interrupt_source[IP_TIMER]));
        rd(COUNT, 3'd0, v, h);
        observe(v);
        repeat (2) @(posedge clock);
        #1;
        rd(COUNT, 3'd0, v, h);
        observe(v);
        repeat (2) @(posedge clock);
        #1;
        observe(64'(interrupt_source[IP_TIMER]));
        while (sb_q.size() != 0) begin
            sb_t e;
            logic [63:0] got;
            e = sb_q.pop_front();
            if (obs_q.size() != 0) got = obs_q.pop_front();
            else got = 'x;
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_wrap;
        logic [63:0] v;
        logic        h;
        mtc0(COUNT, 3'd0, 64'hFFFF_FFFF);
        mtc0(COMPARE, 3'd0, 64'h0);
        expect_val("wrap_count_pre", 64'hFFFF_FFFF);
        expect_val("wrap_src_pre", 64'h0);
        expect_val("wrap_count_post", 64'h0);
        expect_val("wrap_src_post", 64'h80);
        expect_val("wrap_src_cleared", 64'h0);
        rd(COUNT, 3'd0, v, h);
        observe(v);
        observe(64'(interrupt_source));
        @(posedge clock);
        #1;
        rd(COUNT, 3'd0, v, h);
        observe(v);
        observe(64'(interrupt_source));
        mtc0(COMPARE, 3'd0, 64'h1000_0000);
        observe(64'(interrupt_source));
        while (sb_q.size() != 0) begin
            sb_t e;
            logic [63:0] got;
            e = sb_q.pop_front();
            if (obs_q.size() != 0) got = obs_q.pop_front();
            else got = 'x;
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_ext;
        logic [63:0] v;
        logic        h;
        // One-cycle pulse on edge-mode line 0
        expect_val("edge_e1", 64'h00);
        expect_val("edge_e2", 64'h00);
        expect_val("edge_e3", 64'h04);
        expect_val("edge_held", 64'h04);
        expect_val("edge_pend_rd", 64'h01);
        expect_val("edge_cleared", 64'h00);
        expect_val("edge_pend_rd_clr", 64'h00);
        @(negedge clock);
        ext_irq[0] = 1'b1;
        @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        @(negedge clock);
        ext_irq[0] = 1'b0;
        @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        repeat (3) @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        rd(IRQ_PEND, 3'd0, v, h);
        observe(v);
        mtc0(IRQ_PEND, 3'd0, 64'h01);
        observe(64'(interrupt_source));
        rd(IRQ_PEND, 3'd0, v, h);
        observe(v);
        // Clear write lands on the same edge the pending bit is set
        expect_val("edge_set_beats_clr", 64'h04);
        expect_val("edge_clr_again", 64'h00);
        @(negedge clock);
        ext_irq[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ext_irq[0] = 1'b0;
        @(posedge clock);
        #1;
        mtc0(IRQ_PEND, 3'd0, 64'h01);
        observe(64'(interrupt_source));
        mtc0(IRQ_PEND, 3'd0, 64'h01);
        observe(64'(interrupt_source));
        // Level-mode line 1
        expect_val("lvl_e1", 64'h00);
        expect_val("lvl_e2", 64'h08);
        expect_val("lvl_ignores_clr", 64'h08);
        expect_val("lvl_pend_rd", 64'h00);
        expect_val("lvl_fall_e1", 64'h08);
        expect_val("lvl_fall_e2", 64'h00);
        @(negedge clock);
        ext_irq[1] = 1'b1;
        @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        mtc0(IRQ_PEND, 3'd0, 64'h1F);
        observe(64'(interrupt_source));
        rd(IRQ_PEND, 3'd0, v, h);
        observe(v);
        @(negedge clock);
        ext_irq[1] = 1'b0;
        @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        while (sb_q.size() != 0) begin
            sb_t e;
            logic [63:0] got;
            e = sb_q.pop_front();
            if (obs_q.size() != 0) got = obs_q.pop_front();
            else got = 'x;
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_sw_reset;
        logic [63:0] v;
        logic        h;
        expect_val("sw_11", 64'h03);
        expect_val("sw_10", 64'h02);
        expect_val("sw_held", 64'h02);
        expect_val("count_wr_match", 64'h82);
        expect_val("all_pending", 64'h86);
        mtc0(CAUSE, 3'd0, 64'h300);
        observe(64'(interrupt_source));
        mtc0(CAUSE, 3'd0, 64'h200);
        observe(64'(interrupt_source));
        repeat (5) @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        // Count written straight onto Compare (0x1000_0000) fires the timer
        mtc0(COUNT, 3'd0, 64'h1000_0000);
        observe(64'(interrupt_source));
        @(negedge clock);
        ext_irq[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ext_irq[0] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        observe(64'(interrupt_source));
        // Asynchronous reset mid-cycle
        expect_val("arst_src", 64'h00);
        expect_val("arst_count", 64'h0);
        expect_val("arst_pend", 64'h0);
        expect_val("arst_compare", 64'hFFFF_FFFF);
        expect_val("rel_e1_count", 64'h0);
        expect_val("rel_e2_count", 64'h1);
        expect_val("rel_src", 64'h00);
        @(negedge clock);
        #3;
        reset = 1'b1;
        #1;
        observe(64'(interrupt_source));
        rd(COUNT, 3'd0, v, h);
        observe(v);
        rd(IRQ_PEND, 3'd0, v, h);
        observe(v);
        rd(COMPARE, 3'd0, v, h);
        observe(v);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        rd(COUNT, 3'd0, v, h);
        observe(v);
        @(posedge clock);
        #1;
        rd(COUNT, 3'd0, v, h);
        observe(v);
        observe(64'(interrupt_source));
        while (sb_q.size() != 0) begin
            sb_t e;
            logic [63:0] got;
            e = sb_q.pop_front();
            if (obs_q.size() != 0) got = obs_q.pop_front();
            else got = 'x;
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.val);
            end
        end
        obs_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timer_match();
        test_compare_coincide();
        test_wrap();
        test_ext();
        test_sw_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
- Interrupt-source front end directly upstream of the CP0 exception unit.
- Owns the CP0 Count/Compare timer, the two software-interrupt bits (Cause IP1:0) and synchronisation/latching of five external hardware interrupt lines.
- Drives the 8-bit interrupt_source vector that CP0 merges into Cause[15:8].
- Decodes the same MTC0 regnum/sel bus as CP0; reads are returned through its own rd_data with a hit flag for the top-level MFC0 mux.

Parameters:
- COUNT_DIV, 2, core clocks per Count increment (>=1; prescaler width = $clog2(COUNT_DIV)+1).
- EXT_EDGE, 5'b00000, per-line mode for ext_irq[4:0]: 1 = rising-edge latched, 0 = level.
- COMPARE_RESET, 32'hFFFF_FFFF, Compare value after reset.

Ports:
- clock  input  1  core clock
- reset  input  1  asynchronous, active-high
- wr_data  input  64  MTC0 write data; only [31:0] used
- regnum  input  5  CP0 register number
- sel  input  3  CP0 select
- MTC0  input  1  write strobe for this cycle
- ext_irq  input  5  asynchronous external interrupt lines
- rd_data  output  64  read data for the addressed register; zero-extended
- rd_hit  output  1  regnum/sel addresses a register owned by this block
- interrupt_source  output  8  {timer, ext[4:0], sw[1:0]} to CP0

Behaviour:
- Register map (sel=0 unless stated):
  - Count = 9.
  - Compare = 11.
  - Cause = 13, write-only here: bits [9:8] -> sw.
  - IRQ_PEND = 22: read {27'b0, ext_pend[4:0]}; write-1-to-clear ext_pend.
- rd_hit = 1 for (9,0), (11,0), (22,0); reads are combinational; rd_data = 0 when rd_hit = 0.
- Reset values:
  - Count=0, prescaler=0, Compare=COMPARE_RESET.
  - timer_pend=0, sw=0, ext_pend=0, all sync flops=0.
  - interrupt_source=8'h00.
- Prescaler:
  - Increments every cycle.
  - When it equals COUNT_DIV-1 it wraps to 0 and Count increments (mod 2^32; 32'hFFFF_FFFF -> 0, no flag).
- Count write:
  - Loads wr_data[31:0] and clears the prescaler.
  - No increment that cycle.
- Timer match:
  - timer_pend is set on the edge where Count takes a value equal to Compare, by increment or by Count write.
  - It is sticky.
- Compare write:
  - Loads wr_data[31:0] and clears timer_pend.
  - If a match-set and a Compare write coincide, the clear wins.
  - A new Compare equal to the current Count does not set pend until Count is next written to that value or wraps around to it.
- Cause write: sw <= wr_data[9:8] and is held until rewritten. The block never clears sw itself.
- External lines:
  - Each line passes through two flops (s1, s2); a third flop s3 holds the previous s2.
  - Level line i: interrupt_source[2+i] = s2[i]. Visible at the 2nd rising edge after ext_irq rises.
  - Edge line i: ext_pend[i] is set when s2 & ~s3. Visible at the 3rd edge.
  - Edge line i is cleared by an IRQ_PEND write with wr_data[i]=1. If a set and a clear coincide, the set wins, so the edge is not lost.
  - Level lines ignore IRQ_PEND writes; their IRQ_PEND read bit is 0.
- interrupt_source[7] = timer_pend; [1:0] = sw. All outputs come straight from flops, with no combinational path from inputs.
- MTC0 to any unlisted regnum/sel: no state change.
- Asynchronous reset mid-count or with pending bits clears everything immediately. After release, Count resumes from 0 with the prescaler at 0.

Decomposition:
- Shared package cp0_pkg holds:
  - Register-number constants: STATUS=12, CAUSE=13, EPC=14, BADINSTR=8, COUNT=9, COMPARE=11, IRQ_PEND=22.
  - IP bit-index constants: IP_TIMER=7, IP_EXT_LO=2, IP_SW_LO=0.
  - ExcCode localparams.
  - CP0 is to be migrated to this package.
- One sub-module, irq_sync_edge:
  - Covers a single line: 2-flop synchroniser, s3, and the edge pending flop with clear.
  - Parameterised by EDGE.
  - Instantiated five times via generate.

Test Plan:
- Reset, then COUNT_DIV=2, idle 10 cycles -> Count reads 5; interrupt_source=8'h00; Compare reads FFFF_FFFF.
- MTC0 Count=0x10, Compare=0x14 -> interrupt_source[7] rises on the edge where Count becomes 0x14 (8 cycles after the Count write). It stays set until an MTC0 Compare=0x40 clears it the following edge.
- Compare write in the exact cycle the match would occur -> timer_pend remains 0; Count continues to 0x15.
- Count write 0xFFFF_FFFF, Compare=0x0 -> Count wraps to 0 after 2 cycles; timer_pend set, no other effect.
- EXT_EDGE=5'b00001: pulse ext_irq[0] for 1 cycle -> interrupt_source[2] set at 3rd edge and held; IRQ_PEND read=0x01; write 0x01 clears it. Level ext_irq[1] held high -> bit 3 high after 2 edges, drops 2 edges after deassert.
- MTC0 Cause wr_data=0x300 -> interrupt_source[1:0]=2'b11 next edge; assert reset mid-run -> all outputs 0 immediately, Count=0.
